pipe_stage_reg: RTL

Parametrised, elastic pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a packed payload of configurable width under a valid/ready handshake. An optional 2-entry skid buffer registers `in_ready`, so upstream stall logic is not combinational. It supports synchronous flush, and it drives an all-zero payload (`nop`, PC 0) whenever the stage is empty. One instance replaces the fixed-field, WrEn-gated stage registers.

---
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with a valid/ready handshake.
// It carries a packed payload of DATA_W bits between pipeline stages.
// SKID=1 adds a second "skid" entry so that in_ready comes straight from a
// register and has no combinational path from out_ready.
// SKID=0 keeps a single entry and derives in_ready combinationally.
// An empty stage always presents an all-zero payload (a nop bubble at PC 0).
module pipe_stage_reg #(
    parameter int DATA_W = 161,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              flush,      // synchronous clear, beats any handshake
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Number of entries held; the value doubles as the state encoding.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q;      // younger entry; tied to zero when SKID=0
    logic              accept;
    logic              deliver;

    assign out_valid = (count_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign occupancy = count_q;

    // main_q is forced to zero whenever the stage empties, so out_data needs no
    // extra masking to present a bubble.
    assign out_data  = main_q;

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_d;

            // Registered ready: a pure decode of count_q, never of out_ready.
            assign in_ready = (count_q != ST_TWO);

            // Skid entry captures the beat that arrives while main is stalled,
            // and is cleared once it has moved up into main.
            always_comb begin
                skid_d = skid_q;
                if (flush) begin
                    skid_d = '0;
                end else if ((count_q == ST_ONE) && accept && !deliver) begin
                    skid_d = in_data;
                end else if ((count_q == ST_TWO) && deliver) begin
                    skid_d = '0;
                end
            end

            // Skid storage register.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    skid_q <= '0;
                end else begin
                    skid_q <= skid_d;
                end
            end
        end else begin : g_noskid
            // Single entry: can take a new beat only when the current one leaves.
            assign in_ready = !out_valid || out_ready;
            assign skid_q   = '0;
        end
    endgenerate

    // Next-state and main-entry update; flush overrides every handshake.
    always_comb begin
        count_d = count_q;
        main_d  = main_q;
        if (flush) begin
            count_d = ST_EMPTY;
            main_d  = '0;
        end else begin
            case (count_q)
                ST_EMPTY: begin
                    if (accept) begin
                        count_d = ST_ONE;
                        main_d  = in_data;
                    end else begin
                        main_d  = '0;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        main_d  = in_data;
                    end else if (accept) begin
                        // Only reachable with a skid entry; without one,
                        // in_ready already implies deliver here.
                        if (SKID != 0) begin
                            count_d = ST_TWO;
                        end
                    end else if (deliver) begin
                        count_d = ST_EMPTY;
                        main_d  = '0;
                    end
                end
                ST_TWO: begin
                    // in_ready is low, so only the older entry can move.
                    if (deliver) begin
                        count_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    count_d = ST_EMPTY;
                    main_d  = '0;
                end
            endcase
        end
    end

    // Occupancy and main storage registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= ST_EMPTY;
            main_q  <= '0;
        end else begin
            count_q <= count_d;
            main_q  <= main_d;
        end
    end

endmodule
